freq_count_latch: RTL and testbench
===================================

Name: freq_count_latch

Overview:
- Measurement datapath of the frequency meter, directly downstream of the gate-control stage.
- Consumes that stage's w_enable, clear and save levels.
- Counts rising edges of the unknown input signal sig_in in BCD during each gate window, then latches the result for the display/scan stage.
- Everything runs on the fast system clock c_clk; sig_in and the control levels are asynchronous and are synchronised internally.

Parameters:
- DIGITS, 4, number of BCD digits counted and latched.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2).

Ports:
- c_clk  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- sig_in  input  1  signal under measurement; asynchronous.
- w_enable  input  1  count permission level from gate control; asynchronous.
- clear  input  1  gate-control clear level; high holds the counter at zero; asynchronous.
- save  input  1  gate-control save level; its rising edge latches the count; asynchronous.
- bcd_out  output  4*DIGITS  latched BCD result; digit 0 in bits [3:0].
- overflow  output  1  latched: the window exceeded the all-9s value.
- data_valid  output  1  one-cycle pulse, asserted the cycle after bcd_out/overflow update.

Behaviour:
- Reset (reset low, asynchronous):
  - counter = 0, sticky overflow = 0, bcd_out = 0, overflow = 0, data_valid = 0.
  - All synchroniser flops = 0, edge-history flops = 0.
- Synchronisation:
  - sig_in, w_enable, clear and save each pass through SYNC_STAGES flops.
  - One extra history flop each for sig_in and save provides edge detection.
  - sig_rise = synced sig_in & ~history. save_rise is formed the same way.
  - Latency from a pin change to its internal effect is SYNC_STAGES+1 cycles.
- count_en = synced w_enable & ~synced clear.
- Counter:
  - DIGITS cascaded BCD digits. Digit k increments when count_en, sig_rise, and all lower digits are 9.
  - A digit at 9 wraps to 0 with carry.
  - When all digits are 9 and an increment occurs: counter holds at all-9s (saturates) and the sticky overflow flag sets.
- Clear:
  - When synced clear is high, counter and sticky overflow go to 0 on the next edge.
  - Clear has priority over increment.
- Latch:
  - On save_rise, bcd_out and overflow load the counter and sticky overflow values present before this cycle's update.
  - The pre-clear, pre-increment value is captured, so a simultaneous clear or sig_rise never corrupts the captured result.
  - data_valid pulses high the following cycle for exactly 1 cycle.
- Gate-control interaction:
  - save and clear rise together at the end of a window. They pass through matched synchronisers, so save_rise and clear become visible in the same cycle. The latch rule above guarantees the full window count is captured.
  - Counting resumes when clear falls.
- Back-to-back save edges: each rising edge produces one latch and one data_valid. A save level held high produces nothing further.
- w_enable low freezes the counter without clearing it. Latch and clear still operate.
- sig_in frequency must stay below c_clk/2. Behaviour above that is undefined.
- Reset mid-window: everything returns to reset values immediately. The first save_rise after release latches whatever counted since release.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Shared package freq_pkg:
  - BCD digit width constant (4).
  - Constant for digit value 9.
  - Default DIGITS.
  - Function returning the all-9s vector for N digits.
- One natural sub-module: bcd_digit_cnt.
  - Inputs: c_clk, reset, clr, inc_in.
  - Outputs: q[3:0], carry_out.
  - Instantiated DIGITS times in a generate loop.
- Synchronisers are inline flops; no sub-module.

Test Plan:
- Reset: assert reset low mid-count → bcd_out=0, overflow=0, data_valid=0 immediately; counter restarts at 0 after release.
- Basic window, DIGITS=4:
  - Clear low, w_enable high, 1234 sig_in pulses, then save and clear rise together.
  - Required: bcd_out=16'h1234, overflow=0, a single 1-cycle data_valid.
  - Next window starts from 0.
- Digit carry: 999 pulses then latch → 16'h0999; one more pulse in a fresh window of 1000 pulses → 16'h1000.
- Saturation: 10005 pulses in one window → bcd_out=16'h9999, overflow=1; next window of 7 pulses → 16'h0007, overflow=0.
- Simultaneous events:
  - sig_in edge synchronised in the same cycle as save_rise/clear → latched value excludes that edge; counter is 0 after.
  - save held high for 10 cycles → exactly one data_valid.
- w_enable low for 50 pulses mid-window → those pulses are not counted; the count before and after is preserved and summed.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared constants and helpers for the frequency-meter measurement datapath.
package freq_pkg;

  localparam int unsigned DigitW        = 4;
  localparam logic [3:0]  DigitNine     = 4'd9;
  localparam int unsigned DefaultDigits = 4;
  // Upper bound on the digit count supported by all_nines().
  localparam int unsigned MaxDigits     = 16;

  // All-9s BCD vector for n digits, zero-extended to MaxDigits digits.
  function automatic logic [DigitW*MaxDigits-1:0] all_nines(input int unsigned n);
    logic [DigitW*MaxDigits-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MaxDigits; i++) begin
      if (i < n) v[i*DigitW +: DigitW] = DigitNine;
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD decade counter with synchronous clear and ripple carry output.
module bcd_digit_cnt
  import freq_pkg::*;
(
  input  logic              c_clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc_in,
  output logic [DigitW-1:0] q,
  output logic              carry_out
);

  logic [DigitW-1:0] q_q, q_d;

  // Next digit value: clear wins, otherwise count 0..9 and wrap.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc_in) begin
      q_d = (q_q == DigitNine) ? '0 : q_q + 4'd1;
    end
  end

  // Digit state register.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = inc_in & (q_q == DigitNine);

endmodule

// File: rtl/freq_count_latch.sv
// Frequency-meter measurement datapath: synchronises sig_in and gate-control
// levels, counts sig_in rising edges in BCD, and latches the count on save.
module freq_count_latch
  import freq_pkg::*;
#(
  parameter int unsigned DIGITS      = DefaultDigits,  // at most MaxDigits
  parameter int unsigned SYNC_STAGES = 2               // at least 2
) (
  input  logic                     c_clk,
  input  logic                     reset,
  input  logic                     sig_in,
  input  logic                     w_enable,
  input  logic                     clear,
  input  logic                     save,
  output logic [DigitW*DIGITS-1:0] bcd_out,
  output logic                     overflow,
  output logic                     data_valid
);

  localparam int unsigned CntW = DigitW * DIGITS;
  localparam logic [DigitW*MaxDigits-1:0] AllNinesWide = all_nines(DIGITS);
  localparam logic [CntW-1:0] AllNines = AllNinesWide[CntW-1:0];

  // Matched-length synchronisers keep save_rise and clear aligned.
  logic [SYNC_STAGES-1:0] sig_sync_q, en_sync_q, clr_sync_q, save_sync_q;
  logic                   sig_hist_q, save_hist_q;
  logic                   sig_s, en_s, clr_s, save_s;
  logic                   sig_rise, save_rise, count_en, inc;

  // Synchroniser chains and edge-history flops.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      sig_sync_q  <= '0;
      en_sync_q   <= '0;
      clr_sync_q  <= '0;
      save_sync_q <= '0;
      sig_hist_q  <= 1'b0;
      save_hist_q <= 1'b0;
    end else begin
      sig_sync_q  <= {sig_sync_q[SYNC_STAGES-2:0], sig_in};
      en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], w_enable};
      clr_sync_q  <= {clr_sync_q[SYNC_STAGES-2:0], clear};
      save_sync_q <= {save_sync_q[SYNC_STAGES-2:0], save};
      sig_hist_q  <= sig_s;
      save_hist_q <= save_s;
    end
  end

  assign sig_s     = sig_sync_q[SYNC_STAGES-1];
  assign en_s      = en_sync_q[SYNC_STAGES-1];
  assign clr_s     = clr_sync_q[SYNC_STAGES-1];
  assign save_s    = save_sync_q[SYNC_STAGES-1];
  assign sig_rise  = sig_s & ~sig_hist_q;
  assign save_rise = save_s & ~save_hist_q;
  assign count_en  = en_s & ~clr_s;
  assign inc       = count_en & sig_rise;

  logic [CntW-1:0] cnt;
  logic [DIGITS:0] chain;
  logic            at_max;
  logic            unused_top_carry;

  assign at_max = (cnt == AllNines);
  // Gating the chain at all-9s makes the counter saturate instead of wrap.
  assign chain[0] = inc & ~at_max;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cnt u_digit (
      .c_clk     (c_clk),
      .reset     (reset),
      .clr       (clr_s),
      .inc_in    (chain[k]),
      .q         (cnt[k*DigitW +: DigitW]),
      .carry_out (chain[k+1])
    );
  end

  // Never set because the chain input is gated at all-9s.
  assign unused_top_carry = chain[DIGITS];

  logic ovf_sticky_q, ovf_sticky_d;

  // Sticky overflow: cleared by clear, set by an increment attempted at all-9s.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (clr_s) begin
      ovf_sticky_d = 1'b0;
    end else if (inc && at_max) begin
      ovf_sticky_d = 1'b1;
    end
  end

  logic [CntW-1:0] bcd_q;
  logic            ovf_out_q;
  logic            latched_q;
  logic            valid_q;

  // Latch captures pre-update counter state; data_valid follows one cycle later.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      ovf_sticky_q <= 1'b0;
      bcd_q        <= '0;
      ovf_out_q    <= 1'b0;
      latched_q    <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      latched_q    <= save_rise;
      valid_q      <= latched_q;
      if (save_rise) begin
        bcd_q     <= cnt;
        ovf_out_q <= ovf_sticky_q;
      end
    end
  end

  assign bcd_out    = bcd_q;
  assign overflow   = ovf_out_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_freq_count_latch.sv
// Self-checking bench for freq_count_latch: randomised sig_in timing, count
// expectations derived from the number of pulses sent in each window.
module tb_freq_count_latch;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        sig_in;
  logic        w_enable;
  logic        clear;
  logic        save;
  logic [15:0] bcd_out;
  logic        overflow;
  logic        data_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_count = 0;

  freq_count_latch #(
    .DIGITS      (4),
    .SYNC_STAGES (2)
  ) dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .w_enable   (w_enable),
    .clear      (clear),
    .save       (save),
    .bcd_out    (bcd_out),
    .overflow   (overflow),
    .data_valid (data_valid)
  );

  always #5 c_clk = ~c_clk;

  always @(negedge c_clk) if (data_valid) dv_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal count -> 4-digit BCD, saturating at 9999.
  function automatic logic [15:0] model_bcd(input int unsigned count);
    logic [15:0] r;
    int unsigned v;
    v = (count > 9999) ? 9999 : count;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge c_clk);
    #1;
  endtask

  task automatic send(input int n, input bit fast);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      tick(fast ? 1 : int'($urandom_range(1, 2)));
      sig_in = 1'b0;
      tick(fast ? 2 : int'($urandom_range(2, 3)));
    end
  endtask

  task automatic open_window();
    save     = 1'b0;
    clear    = 1'b0;
    w_enable = 1'b1;
    tick(5);
  endtask

  // End the window like gate control (save and clear together) and check the latch.
  task automatic close_and_check(input string tag, input int unsigned count, input bit edge_at_save);
    int  base;
    bit  seen;
    base = dv_count;
    seen = 1'b0;
    tick(6);
    if (edge_at_save) sig_in = 1'b1;
    save  = 1'b1;
    clear = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge c_clk);
      if (data_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_dv_seen"}, 32'(seen), 32'd1);
    check({tag, "_bcd"}, 32'(bcd_out), 32'(model_bcd(count)));
    check({tag, "_ovf"}, 32'(overflow), 32'(count > 9999));
    @(negedge c_clk);
    check({tag, "_dv_width"}, 32'(data_valid), 32'd0);
    tick(10);
    check({tag, "_dv_once"}, 32'(dv_count - base), 32'd1);
    save   = 1'b0;
    sig_in = 1'b0;
  endtask

  initial begin
    int unsigned n;
    reset    = 1'b0;
    sig_in   = 1'b0;
    w_enable = 1'b0;
    clear    = 1'b0;
    save     = 1'b0;
    tick(3);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    reset = 1'b1;
    tick(2);

    // Basic window.
    open_window();
    send(1234, 1'b0);
    close_and_check("basic", 1234, 1'b0);

    // Digit carry boundaries.
    open_window();
    send(999, 1'b0);
    close_and_check("c999", 999, 1'b0);
    open_window();
    send(1000, 1'b0);
    close_and_check("c1000", 1000, 1'b0);

    // Asynchronous reset mid-window, then a fresh count after release.
    open_window();
    send(100, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("midrst_bcd", 32'(bcd_out), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_dv", 32'(data_valid), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(5);
    send(37, 1'b0);
    close_and_check("postrst", 37, 1'b0);

    // Saturation and recovery.
    open_window();
    send(10005, 1'b1);
    close_and_check("sat", 10005, 1'b0);
    open_window();
    send(7, 1'b0);
    close_and_check("after_sat", 7, 1'b0);

    // sig_in edge arriving with save/clear is excluded; counter restarts at 0.
    open_window();
    send(25, 1'b0);
    close_and_check("simul", 25, 1'b1);
    open_window();
    send(12, 1'b0);
    close_and_check("post_simul", 12, 1'b0);

    // w_enable low freezes the count.
    open_window();
    send(40, 1'b0);
    w_enable = 1'b0;
    tick(5);
    send(50, 1'b0);
    w_enable = 1'b1;
    tick(5);
    send(60, 1'b0);
    close_and_check("freeze", 100, 1'b0);

    // Empty window and random-length windows.
    open_window();
    close_and_check("empty", 0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      n = $urandom_range(1, 400);
      open_window();
      send(int'(n), 1'b0);
      close_and_check($sformatf("rnd%0d", w), n, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
